playfield_store: RTL and testbench



---
 rtl/playfield_store_pkg.sv | 26 ++
 rtl/playfield_store_row_full.sv | 18 +
 rtl/playfield_store.sv | 139 +++++++++++++
 tb/tb_playfield_store.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/playfield_store_pkg.sv
// Shared display types: tile encoding, playfield dimensions and line-clear FSM states.
package DisplayPkg;

  typedef enum logic [2:0] {
    BLANK  = 3'd0,
    TILE_I = 3'd1,
    TILE_O = 3'd2,
    TILE_T = 3'd3,
    TILE_S = 3'd4,
    TILE_Z = 3'd5,
    TILE_J = 3'd6,
    TILE_L = 3'd7
  } tile_type_t;

  localparam int PLAYFIELD_ROWS = 20;
  localparam int PLAYFIELD_COLS = 10;
  localparam int PF_ROW_W       = $clog2(PLAYFIELD_ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } clr_state_t;

endpackage

// File: rtl/playfield_store_row_full.sv
// Combinational full-row detector: high when no column of the row holds BLANK.
module playfield_row_full
  import DisplayPkg::*;
#(
  parameter int COLS = PLAYFIELD_COLS
) (
  input  tile_type_t row_i [COLS],
  output logic       full_o
);

  always_comb begin
    full_o = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (row_i[c] == BLANK) full_o = 1'b0;
    end
  end

endmodule

// File: rtl/playfield_store.sv
// Playfield tile store with single-tile writes and a scan/shift line-clear engine.
// Optional macro PLAYFIELD_DOUBLE_BUFFER_EN adds a display copy updated on frame_sync while idle.
module playfield_store
  import DisplayPkg::*;
#(
  parameter int ROWS = PLAYFIELD_ROWS,
  parameter int COLS = PLAYFIELD_COLS
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [$clog2(ROWS)-1:0]    wr_row,
  input  logic [$clog2(COLS)-1:0]    wr_col,
  input  tile_type_t                 wr_type,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       clr_done,
  output logic [$clog2(ROWS+1)-1:0]  lines_cleared,
  input  logic                       frame_sync,
  output tile_type_t                 tile_type [ROWS][COLS]
);

  localparam int RW = $clog2(ROWS);
  localparam int LW = $clog2(ROWS+1);

  clr_state_t     state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [LW-1:0]  count_q, count_d;
  logic [LW-1:0]  lines_q, lines_d;
  tile_type_t     field_q [ROWS][COLS];
  tile_type_t     field_d [ROWS][COLS];
  tile_type_t     scan_row [COLS];
  logic           row_full;
  logic           wr_fire;
  logic           wr_in_range;

  assign scan_row    = field_q[row_q];
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);

  playfield_row_full #(.COLS(COLS)) u_row_full (
    .row_i  (scan_row),
    .full_o (row_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req) state_d = SCAN;
      SCAN: begin
        if (row_full)            state_d = SHIFT;
        else if (row_q == '0)    state_d = DONE;
      end
      SHIFT:   state_d = SCAN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // lines_cleared shows the fresh count during DONE, then the latched copy afterwards.
  always_comb begin
    wr_ready      = (state_q == IDLE);
    busy          = (state_q != IDLE);
    clr_done      = (state_q == DONE);
    lines_cleared = (state_q == DONE) ? count_q : lines_q;
  end

  // SHIFT stays on the same row index so a collapsed full row is rescanned.
  always_comb begin
    field_d = field_q;
    row_d   = row_q;
    count_d = count_q;
    lines_d = lines_q;
    case (state_q)
      IDLE: begin
        if (wr_fire && wr_in_range) field_d[wr_row][wr_col] = wr_type;
        if (clr_req) begin
          row_d   = RW'(ROWS-1);
          count_d = '0;
        end
      end
      SCAN: begin
        if (!row_full && row_q != '0) row_d = row_q - RW'(1);
      end
      SHIFT: begin
        for (int r = ROWS-1; r > 0; r--) begin
          if (r <= int'(row_q)) field_d[r] = field_q[r-1];
        end
        for (int c = 0; c < COLS; c++) field_d[0][c] = BLANK;
        count_d = count_q + LW'(1);
      end
      DONE:    lines_d = count_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q   <= RW'(ROWS-1);
      count_q <= '0;
      lines_q <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) field_q[r][c] <= BLANK;
      end
    end else begin
      row_q   <= row_d;
      count_q <= count_d;
      lines_q <= lines_d;
      field_q <= field_d;
    end
  end

`ifdef PLAYFIELD_DOUBLE_BUFFER_EN
  tile_type_t disp_q [ROWS][COLS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) disp_q[r][c] <= BLANK;
      end
    end else if (frame_sync && state_q == IDLE) begin
      disp_q <= field_q;
    end
  end

  assign tile_type = disp_q;
`else
  logic unused_frame_sync;
  assign unused_frame_sync = frame_sync;
  assign tile_type = field_q;
`endif

endmodule

// File: tb/tb_playfield_store.sv
// Directed bench for playfield_store: table-driven writes plus hand-written clear/reset sequences.
module tb_playfield_store;
  import DisplayPkg::*;

  localparam int ROWS = PLAYFIELD_ROWS;
  localparam int COLS = PLAYFIELD_COLS;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       clr_req = 1'b0;
  logic       frame_sync = 1'b0;
  logic [4:0] wr_row = '0;
  logic [3:0] wr_col = '0;
  tile_type_t wr_type = BLANK;
  logic       wr_ready, busy, clr_done;
  logic [4:0] lines_cleared;
  tile_type_t tile_type [ROWS][COLS];

  tile_type_t model   [ROWS][COLS];
  tile_type_t dispExp [ROWS][COLS];
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         row;
    int         col;
    tile_type_t t;
    tile_type_t expTile;
  } wr_vec_t;

  wr_vec_t vecs [7];

  always #5 clk = ~clk;

  playfield_store dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_row        (wr_row),
    .wr_col        (wr_col),
    .wr_type       (wr_type),
    .clr_req       (clr_req),
    .busy          (busy),
    .clr_done      (clr_done),
    .lines_cleared (lines_cleared),
    .frame_sync    (frame_sync),
    .tile_type     (tile_type)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkField(input string name);
    int bad;
    int br, bc, ba, be;
    bad = 0; br = 0; bc = 0; ba = 0; be = 0;
    checks++;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
`ifdef PLAYFIELD_DOUBLE_BUFFER_EN
        if (tile_type[r][c] != dispExp[r][c] && bad == 0) begin
          bad = 1; br = r; bc = c; ba = int'(tile_type[r][c]); be = int'(dispExp[r][c]);
        end
`else
        if (tile_type[r][c] != model[r][c] && bad == 0) begin
          bad = 1; br = r; bc = c; ba = int'(tile_type[r][c]); be = int'(model[r][c]);
        end
`endif
      end
    end
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL %s: tile[%0d][%0d] actual=%0d expected=%0d", name, br, bc, ba, be);
    end
  endtask

  task automatic clearModel();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        model[r][c]   = BLANK;
        dispExp[r][c] = BLANK;
      end
    end
  endtask

  // In double-buffer builds the display only catches up on an idle frame_sync.
  task automatic settle();
`ifdef PLAYFIELD_DOUBLE_BUFFER_EN
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    dispExp = model;
`endif
  endtask

  task automatic applyStimulus(input int r, input int c, input tile_type_t t);
    wr_valid = 1'b1;
    wr_row   = 5'(r);
    wr_col   = 4'(c);
    wr_type  = t;
    @(negedge clk);
    wr_valid = 1'b0;
    if (r < ROWS && c < COLS) model[r][c] = t;
  endtask

  task automatic fillRow(input int r, input tile_type_t t);
    for (int c = 0; c < COLS; c++) applyStimulus(r, c, t);
  endtask

  // Reference compaction: keep non-full rows in order, packed against the bottom.
  task automatic compactModel(output int lines);
    tile_type_t tmp [ROWS][COLS];
    int dst;
    bit full;
    lines = 0;
    dst = ROWS - 1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) tmp[r][c] = BLANK;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (model[r][c] == BLANK) full = 1'b0;
      if (full) lines++;
      else begin
        tmp[dst] = model[r];
        dst--;
      end
    end
    model = tmp;
  endtask

  // mode 0: plain pass, 1: write + clr_req during pass, 2: frame_sync during pass
  task automatic runClear(input string name, input int mode);
    int expLines, expCycles, n, seen;
    compactModel(expLines);
    expCycles = ROWS + 2 * expLines + 1;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    checkOutput({name, " busy_after_req"}, int'(busy), 1);
    for (n = 1; n < 200; n++) begin
      if (clr_done) break;
      if (mode == 1 && n == 5) begin
        wr_valid = 1'b1; wr_row = 5'd0; wr_col = 4'd0; wr_type = TILE_T; clr_req = 1'b1;
        checkOutput({name, " wr_ready_in_pass"}, int'(wr_ready), 0);
      end
      if (mode == 1 && n == 6) begin
        wr_valid = 1'b0; clr_req = 1'b0;
      end
      if (mode == 2 && n == 3) frame_sync = 1'b1;
      if (mode == 2 && n == 4) frame_sync = 1'b0;
      @(negedge clk);
    end
    wr_valid = 1'b0; clr_req = 1'b0; frame_sync = 1'b0;
    checkOutput({name, " done_cycle"}, n, expCycles);
    checkOutput({name, " lines_at_done"}, int'(lines_cleared), expLines);
    @(negedge clk);
    checkOutput({name, " busy_after_done"}, int'(busy), 0);
    checkOutput({name, " lines_held"}, int'(lines_cleared), expLines);
    if (mode == 1) begin
      seen = 0;
      for (int k = 0; k < 30; k++) begin
        if (clr_done) seen = 1;
        @(negedge clk);
      end
      checkOutput({name, " no_second_done"}, seen, 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{5,  3,  TILE_T, TILE_T};
    vecs[1] = '{0,  0,  TILE_L, TILE_L};
    vecs[2] = '{19, 9,  TILE_J, TILE_J};
    vecs[3] = '{5,  3,  TILE_S, TILE_S};
    vecs[4] = '{25, 2,  TILE_Z, BLANK};
    vecs[5] = '{3,  12, TILE_I, BLANK};
    vecs[6] = '{0,  0,  BLANK,  BLANK};

    clearModel();
    repeat (2) @(negedge clk);
    checkField("reset_field_during_reset");
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("reset wr_ready", int'(wr_ready), 1);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset clr_done", int'(clr_done), 0);
    checkOutput("reset lines_cleared", int'(lines_cleared), 0);
    checkField("reset_field");

    $display("[TB] table-driven writes");
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("vec%0d wr_ready", i), int'(wr_ready), 1);
      applyStimulus(vecs[i].row, vecs[i].col, vecs[i].t);
`ifndef PLAYFIELD_DOUBLE_BUFFER_EN
      if (vecs[i].row < ROWS && vecs[i].col < COLS)
        checkOutput($sformatf("vec%0d tile_next_cycle", i),
                    int'(tile_type[vecs[i].row][vecs[i].col]), int'(vecs[i].expTile));
`endif
      settle();
      checkField($sformatf("vec%0d field", i));
    end

    $display("[TB] single line clear");
    reset_n = 1'b0;
    #1;
    clearModel();
    @(negedge clk);
    reset_n = 1'b1;
    fillRow(19, TILE_I);
    applyStimulus(18, 4, TILE_O);
    runClear("clear1", 0);
    settle();
    checkField("clear1 field");
    checkOutput("clear1 tile19_4", int'(tile_type[19][4]), int'(TILE_O));

    $display("[TB] two separated line clears");
    fillRow(19, TILE_Z);
    fillRow(17, TILE_Z);
    applyStimulus(18, 0, TILE_S);
    applyStimulus(16, 9, TILE_S);
    runClear("clear2", 0);
    settle();
    checkField("clear2 field");
    checkOutput("clear2 tile19_0", int'(tile_type[19][0]), int'(TILE_S));
    checkOutput("clear2 tile18_9", int'(tile_type[18][9]), int'(TILE_S));

    $display("[TB] writes and requests during a pass");
    runClear("nofull", 1);
    settle();
    checkField("nofull field");
    applyStimulus(25, 2, TILE_T);
    settle();
    checkField("oor write field");

    $display("[TB] all rows full");
    for (int r = 0; r < ROWS; r++) fillRow(r, TILE_L);
    runClear("allfull", 0);
    settle();
    checkField("allfull field");

    $display("[TB] reset during shift");
    fillRow(19, TILE_J);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    clearModel();
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset wr_ready", int'(wr_ready), 1);
    checkField("midreset field");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(2, 2, TILE_T);
    settle();
    checkField("after reset write");

`ifdef PLAYFIELD_DOUBLE_BUFFER_EN
    $display("[TB] double buffer");
    applyStimulus(10, 1, TILE_O);
    checkField("dbuf write hidden");
    fillRow(19, TILE_I);
    runClear("dbuf clear", 2);
    checkField("dbuf sync skipped");
    settle();
    checkField("dbuf compacted");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
